stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DWIDTH, default 16: data width in bits; legal range 1..512.
REQ-002 Parameter DEPTH, default 256: capacity in words; power of two; legal range 4..65536.
REQ-003 Parameter AFULL_LVL, default DEPTH-4: almost_full asserts when count >= AFULL_LVL.
REQ-004 Parameter AEMPTY_LVL, default 4: almost_empty asserts when count <= AEMPTY_LVL.
REQ-005 aclk  in  1: sole clock; all logic on rising edge.
REQ-006 aresetn  in  1: reset, asynchronous assert, active-low.
REQ-007 flush  in  1: synchronous clear of all contents; active-high.
REQ-008 s_valid  in  1: write-side word valid.
REQ-009 s_ready  out  1: write side can accept a word.
REQ-010 s_data  in  DWIDTH: write-side word.
REQ-011 m_valid  out  1: read-side word valid.
REQ-012 m_ready  in  1: read-side consumer accepts.
REQ-013 m_data  out  DWIDTH: read-side word, registered output.
REQ-014 count  out  $clog2(DEPTH)+1: words held, 0..DEPTH.
REQ-015 almost_full  out  1: registered threshold flag.
REQ-016 almost_empty  out  1: registered threshold flag.

Function
REQ-017 A write SHALL occur on an edge where s_valid && s_ready; a read SHALL occur on an edge where m_valid && m_ready.
REQ-018 s_ready SHALL be (count != DEPTH) and SHALL NOT depend combinationally on s_valid or m_ready.
REQ-019 Words SHALL be delivered in write order with no loss, duplication or corruption.
REQ-020 Storage SHALL be one simple-dual-port RAM with one-cycle registered read plus one output register; m_data comes from the output register.
REQ-021 Into an empty FIFO: word written at edge N SHALL produce m_valid=1 with that word after edge N+2.
REQ-022 m_valid and m_data SHALL stay stable while m_valid && !m_ready.
REQ-023 With the FIFO non-empty and m_ready held high, one word SHALL be delivered every cycle, no bubbles.
REQ-024 count SHALL update on each edge: +1 write only, -1 read only, unchanged for both or neither; count includes words in RAM, in flight, and in the output register.
REQ-025 Simultaneous write and read at count == DEPTH SHALL not occur (s_ready low); at count == 0 a write SHALL be accepted and no read occurs.
REQ-026 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-027 Simultaneous read and write of the same RAM address SHALL return the old contents; the control logic SHALL never issue a read of an address being written in the same cycle for valid data.
REQ-028 almost_full and almost_empty SHALL reflect the post-edge count on the same edge count updates.
REQ-029 flush=1 at an edge SHALL set count=0, pointers=0, m_valid=0, and ignore any concurrent write or read; flush has priority over all traffic.
REQ-030 RAM contents SHALL not be cleared by reset or flush; data visibility is governed only by pointers and m_valid.

Reset
REQ-031 While aresetn=0: count=0, pointers=0, m_valid=0, m_data=0, s_ready=0, almost_full=0, almost_empty=1.
REQ-032 s_ready SHALL rise on the first edge after aresetn deasserts; reset mid-operation discards all contents.

Structure
REQ-033 A shared package SHALL hold the default DWIDTH/DEPTH constants and a helper function for pointer width.
REQ-034 A single sub-module sdp_ram (parameters DWIDTH, DEPTH; write enable, write address, read enable, read address, registered read data) SHALL hold storage; all flow control lives in stream_fifo.

Verification (DEPTH=8, DWIDTH=16, AFULL_LVL=6, AEMPTY_LVL=2)
REQ-035 Write 0x0001 into empty FIFO at edge N, m_ready=1 -> m_valid=1, m_data=0x0001 after edge N+2; count 1 then 0.
REQ-036 Write 8 words 0x10..0x17 with m_ready=0 -> s_ready=0 and count=8 after 8th write; almost_full=1 from count 6; 9th s_valid is not accepted.
REQ-037 Continuous s_valid and m_ready for 40 words 0..39 -> output 0..39 in order, one per cycle after fill latency, count steady, pointers wrap 5 times.
REQ-038 Random s_valid/m_ready (50%) for 1000 words -> scoreboard matches, m_data stable under back-pressure, count always equals accepted minus delivered.
REQ-039 Fill 5 words, assert flush for one cycle with s_valid=1 -> count=0, m_valid=0, the concurrent word discarded; next write 0xABCD is the first word out.
REQ-040 Drop aresetn mid-stream with count=5 -> all outputs at REQ-031 values immediately; after release, first written word is first delivered.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared defaults and pointer-width helper for stream_fifo
package stream_fifo_pkg;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_DEPTH  = 256;

    // Address width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_sdp_ram.sv
// rtl/stream_fifo_sdp_ram.sv - simple-dual-port RAM with registered read data
module sdp_ram
    import stream_fifo_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    // Storage has no reset; a same-address read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FIFO over a registered-read RAM plus output register
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DWIDTH-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DWIDTH-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_vld_q, rd_vld_d;
    logic              m_valid_q, m_valid_d;
    logic [DWIDTH-1:0] m_data_q, m_data_d;
    logic              s_ready_q, s_ready_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;

    logic              s_fire;
    logic              m_fire;
    logic              advance;
    logic              issue;
    logic              ram_we;
    logic              ram_re;
    logic [CW-1:0]     ram_words;
    logic [DWIDTH-1:0] rd_data;

    sdp_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Handshakes, read-pipeline scheduling and next-state for all control flops.
    always_comb begin
        s_fire    = s_valid && s_ready_q;
        m_fire    = m_valid_q && m_ready;
        // RAM read register hands its word on when the output slot is free or draining.
        advance   = rd_vld_q && (!m_valid_q || m_ready);
        // Words still sitting in RAM, not yet fetched into the pipeline.
        ram_words = count_q - CW'(rd_vld_q) - CW'(m_valid_q);
        // Fetch only committed words, and only when the read register frees up,
        // so a valid read never targets the address being written this cycle.
        issue     = (ram_words != '0) && (!rd_vld_q || advance);
        ram_we    = s_fire && !flush;
        ram_re    = issue && !flush;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_vld_d  = rd_vld_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rd_vld_d  = 1'b0;
            m_valid_d = 1'b0;
        end else begin
            if (s_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({s_fire, m_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (issue) begin
                rd_vld_d = 1'b1;
            end else if (advance) begin
                rd_vld_d = 1'b0;
            end
            if (advance) begin
                m_valid_d = 1'b1;
                m_data_d  = rd_data;
            end else if (m_fire) begin
                m_valid_d = 1'b0;
            end
        end

        s_ready_d = (count_d != DEPTH_C);
        afull_d   = (count_d >= AFULL_C);
        aempty_d  = (count_d <= AEMPTY_C);
    end

    // Control and status registers; reset forces the idle, not-ready state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_vld_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_ready_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_vld_q  <= rd_vld_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_ready_q <= s_ready_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign count        = count_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - directed and randomized self-checking bench for stream_fifo
module tb_stream_fifo;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [3:0]    count;
    logic          almost_full;
    logic          almost_empty;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] sb [$];
    int            ndeliv   = 0;
    int            nsent    = 0;
    logic [DW-1:0] last_out = '0;

    stream_fifo #(
        .DWIDTH     (DW),
        .DEPTH      (DP),
        .AFULL_LVL  (AF),
        .AEMPTY_LVL (AE)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: score the handshakes visible now, advance, then check the model.
    task automatic step();
        bit            sf;
        bit            mf;
        bit            stall;
        int            cnt;
        logic [DW-1:0] pd;
        sf    = s_valid && s_ready;
        mf    = m_valid && m_ready;
        stall = m_valid && !m_ready && !flush;
        pd    = m_data;
        if (flush) begin
            sb.delete();
        end else begin
            if (mf) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check_eq("data_order", 32'(m_data), 32'(sb.pop_front()));
                end
                last_out = m_data;
                ndeliv++;
            end
            if (sf) begin
                sb.push_back(s_data);
                nsent++;
            end
        end
        @(posedge aclk);
        #1;
        cnt = sb.size();
        check_eq("count_model", 32'(count), 32'(cnt));
        check_eq("afull_model", 32'(almost_full), 32'(cnt >= AF));
        check_eq("aempty_model", 32'(almost_empty), 32'(cnt <= AE));
        if (stall) begin
            check_eq("hold_valid", 32'(m_valid), 32'd1);
            check_eq("hold_data", 32'(m_data), 32'(pd));
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_deliv(input int target, input int max_cyc);
        int n;
        n = 0;
        while (ndeliv < target && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("deliv_timeout", 32'(ndeliv >= target), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        aresetn = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset values
        @(posedge aclk);
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_afull", 32'(almost_full), 32'd0);
        check_eq("rst_aempty", 32'(almost_empty), 32'd1);
        aresetn = 1'b1;
        step();
        check_eq("ready_after_rst", 32'(s_ready), 32'd1);

        // Single word latency: write at edge N, visible after N+2
        s_valid = 1'b1;
        s_data  = 16'h0001;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        check_eq("lat_cnt_n", 32'(count), 32'd1);
        check_eq("lat_mv_n", 32'(m_valid), 32'd0);
        step();
        check_eq("lat_mv_n1", 32'(m_valid), 32'd0);
        step();
        check_eq("lat_mv_n2", 32'(m_valid), 32'd1);
        check_eq("lat_md_n2", 32'(m_data), 32'h0001);
        check_eq("lat_cnt_n2", 32'(count), 32'd1);
        step();
        check_eq("lat_cnt_end", 32'(count), 32'd0);
        check_eq("lat_mv_end", 32'(m_valid), 32'd0);

        // Fill to full with the reader stalled
        m_ready = 1'b0;
        for (int i = 0; i < DP; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h10 + i);
            step();
            check_eq("fill_count", 32'(count), 32'(i + 1));
            check_eq("fill_afull", 32'(almost_full), 32'(i + 1 >= AF));
        end
        check_eq("full_s_ready", 32'(s_ready), 32'd0);
        s_data = 16'h0099;
        step();
        check_eq("full_9th_cnt", 32'(count), 32'd8);
        check_eq("full_head", 32'(m_data), 32'h0010);
        drain(40);
        check_eq("drain_aempty", 32'(almost_empty), 32'd1);

        // Streaming 40 words back to back: no bubbles, steady count
        base    = ndeliv;
        m_ready = 1'b1;
        for (int k = 0; k < 43; k++) begin
            s_valid = (k < 40);
            s_data  = 16'(k);
            if (k >= 3) begin
                check_eq("stream_mvalid", 32'(m_valid), 32'd1);
            end
            step();
            if (k == 20) begin
                check_eq("stream_count", 32'(count), 32'd3);
            end
        end
        check_eq("stream_delivered", 32'(ndeliv - base), 32'd40);
        check_eq("stream_empty", 32'(count), 32'd0);

        // Random traffic, 1000 words
        base  = ndeliv;
        nsent = 0;
        n     = 0;
        while (ndeliv < base + 1000 && n < 20000) begin
            s_valid = (nsent < 1000) && ($urandom_range(0, 1) == 1);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            step();
            n++;
        end
        check_eq("rand_delivered", 32'(ndeliv - base), 32'd1000);
        s_valid = 1'b0;
        drain(40);

        // Flush with a concurrent write
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h20 + i);
            step();
        end
        check_eq("pre_flush_cnt", 32'(count), 32'd5);
        flush  = 1'b1;
        s_data = 16'h5555;
        step();
        flush = 1'b0;
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_mvalid", 32'(m_valid), 32'd0);
        s_data = 16'hABCD;
        step();
        s_valid = 1'b0;
        m_ready = 1'b1;
        base = ndeliv;
        wait_deliv(base + 1, 20);
        check_eq("flush_first_out", 32'(last_out), 32'hABCD);

        // Asynchronous reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h40 + i);
            step();
        end
        s_valid = 1'b0;
        check_eq("pre_rst_cnt", 32'(count), 32'd5);
        aresetn = 1'b0;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_m_valid", 32'(m_valid), 32'd0);
        check_eq("arst_m_data", 32'(m_data), 32'd0);
        check_eq("arst_s_ready", 32'(s_ready), 32'd0);
        check_eq("arst_afull", 32'(almost_full), 32'd0);
        check_eq("arst_aempty", 32'(almost_empty), 32'd1);
        sb.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check_eq("arst_ready_low", 32'(s_ready), 32'd0);
        step();
        check_eq("arst_ready_rise", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = 16'h1234;
        step();
        s_valid = 1'b0;
        m_ready = 1'b1;
        base = ndeliv;
        wait_deliv(base + 1, 20);
        check_eq("arst_first_out", 32'(last_out), 32'h1234);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
